// File: rtl/sys_arr_pkg.sv
// Shared state encoding, defaults and row-count helper for the
// systolic-array row sequencer.
package sys_arr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_FIRE = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } seq_state_e;

   localparam int MAC_LAT_DEFAULT = 3;

   // A zero or oversized request runs a full tile of n rows.
   function automatic int unsigned effective_rows(input int unsigned cfg,
                                                  input int unsigned n);
      return ((cfg == 0) || (cfg > n)) ? n : cfg;
   endfunction

endpackage

// File: rtl/sysarr_start_skew.sv
// N-stage shift register that staggers the column-0 MAC start pulse
// across the array, one column per cycle, with a synchronous clear.
module sysarr_start_skew #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         fire_i,
   output logic [N-1:0] start_o
);

   logic [N-1:0] skew_q;
   logic [N-1:0] skew_d;

   always_comb begin
      skew_d    = '0;
      skew_d[0] = fire_i;
      for (int k = 1; k < N; k++) begin
         skew_d[k] = skew_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (clr_i) begin
         skew_q <= '0;
      end else begin
         skew_q <= skew_d;
      end
   end

   assign start_o = skew_q;

endmodule

// File: rtl/sysarr_sequencer.sv
// Row sequencer for an N x N systolic MAC array: loads one input row,
// fires the skewed MAC starts, waits for the last column and strobes capture.
module sysarr_sequencer #(
   parameter int N       = 4,
   parameter int MAC_LAT = sys_arr_pkg::MAC_LAT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic                 start_req,
   input  logic [$clog2(N):0]   cfg_rows,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 out_ready,
   output logic                 mac_shift,
   output logic [N-1:0]         mac_start,
   input  logic                 value_ready_last,
   output logic                 result_capture,
   output logic [$clog2(N)-1:0] row_idx,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   import sys_arr_pkg::*;

   localparam int CW       = $clog2(N) + 1;
   localparam int RW       = $clog2(N);
   localparam int WAIT_CYC = N + MAC_LAT - 1;
   localparam int WW       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   localparam int WLAST    = WAIT_CYC - 1;

   seq_state_e    state_q,   state_d;
   logic [RW-1:0] row_idx_q, row_idx_d;
   logic [CW-1:0] rows_q,    rows_d;
   logic [WW-1:0] wcnt_q,    wcnt_d;
   logic          err_q,     err_d;

   logic [CW-1:0] rows_eff;
   logic          handshake;
   logic          wait_last;
   logic          last_row;
   logic          fire_next;
   logic [N-1:0]  skew_start;

   assign rows_eff  = CW'(effective_rows(32'(cfg_rows), 32'(N)));
   assign handshake = (state_q == ST_LOAD) && in_valid && out_ready;
   assign wait_last = (state_q == ST_WAIT) && (wcnt_q == WW'(WLAST));
   assign last_row  = ((CW'(row_idx_q) + CW'(1)) == rows_q);

   always_comb begin
      state_d   = state_q;
      row_idx_d = row_idx_q;
      rows_d    = rows_q;
      wcnt_d    = wcnt_q;
      err_d     = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               state_d   = ST_LOAD;
               rows_d    = rows_eff;
               row_idx_d = '0;
               err_d     = 1'b0;
            end
         end
         ST_LOAD: begin
            if (handshake) begin
               state_d = ST_FIRE;
            end
         end
         ST_FIRE: begin
            state_d = ST_WAIT;
            wcnt_d  = '0;
         end
         ST_WAIT: begin
            // The last column must report exactly in the final WAIT cycle.
            if (wait_last) begin
               if (!value_ready_last) begin
                  err_d = 1'b1;
               end
               if (last_row) begin
                  state_d = ST_DONE;
               end else begin
                  state_d   = ST_LOAD;
                  row_idx_d = row_idx_q + RW'(1);
               end
            end else begin
               wcnt_d = wcnt_q + WW'(1);
               if (value_ready_last) begin
                  err_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         row_idx_q <= '0;
         rows_q    <= '0;
         wcnt_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_idx_q <= row_idx_d;
         rows_q    <= rows_d;
         wcnt_q    <= wcnt_d;
         err_q     <= err_d;
      end
   end

   // Loading stage 0 on entry makes mac_start[0] a registered FIRE-cycle pulse.
   assign fire_next = (state_d == ST_FIRE);

   sysarr_start_skew #(
      .N(N)
   ) u_skew (
      .clk    (clk),
      .clr_i  (RST),
      .fire_i (fire_next),
      .start_o(skew_start)
   );

   // Outputs are forced low while RST is high so nothing leaks mid-reset;
   // mac_shift is the LOAD handshake itself and so follows the inputs.
   assign in_ready       = ~RST & (state_q == ST_LOAD) & out_ready;
   assign mac_shift      = in_ready & in_valid;
   assign mac_start      = RST ? '0 : skew_start;
   assign result_capture = ~RST & wait_last;
   assign row_idx        = RST ? '0 : row_idx_q;
   assign busy           = ~RST & (state_q != ST_IDLE);
   assign done           = ~RST & (state_q == ST_DONE);
   assign err            = ~RST & err_q;

endmodule

// File: tb/tb_sysarr_sequencer.sv
// Directed bench for sysarr_sequencer (N=4, MAC_LAT=3) with a behavioural
// last-column MAC and a capture scoreboard keyed on cycle and row.
module tb_sysarr_sequencer;

   localparam int N       = 4;
   localparam int MAC_LAT = 3;

   logic         clk;
   logic         RST;
   logic         start_req;
   logic [2:0]   cfg_rows;
   logic         in_valid;
   logic         in_ready;
   logic         out_ready;
   logic         mac_shift;
   logic [N-1:0] mac_start;
   logic         value_ready_last;
   logic         result_capture;
   logic [1:0]   row_idx;
   logic         busy;
   logic         done;
   logic         err;

   sysarr_sequencer #(
      .N      (N),
      .MAC_LAT(MAC_LAT)
   ) dut (
      .clk             (clk),
      .RST             (RST),
      .start_req       (start_req),
      .cfg_rows        (cfg_rows),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .out_ready       (out_ready),
      .mac_shift       (mac_shift),
      .mac_start       (mac_start),
      .value_ready_last(value_ready_last),
      .result_capture  (result_capture),
      .row_idx         (row_idx),
      .busy            (busy),
      .done            (done),
      .err             (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Last-column MAC: ready MAC_LAT cycles after its start pulse.
   logic [MAC_LAT-1:0] hist = '0;
   logic suppress = 1'b0;
   logic inject_vr = 1'b0;
   always @(posedge clk) hist <= {hist[MAC_LAT-2:0], mac_start[N-1]};
   assign value_ready_last = (hist[MAC_LAT-1] & ~suppress) | inject_vr;

   logic [11:0] outs;
   assign outs = {mac_start, mac_shift, in_ready, result_capture, row_idx, busy, done, err};

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      int cyc;
      int row;
   } cap_t;
   cap_t cap_q[$];

   int t0 = 0;
   int iv_from, or_from, inject_at, bs_at, rst_at;
   int shift_cyc, done_cyc, idle_cyc, n_shift, err_at_done;
   int ms_cyc[N];
   int ir1, err1, err6, err10, outs5, outs6;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (result_capture) begin
         chk("cap_pending", int'(cap_q.size() > 0), 1);
         if (cap_q.size() > 0) begin
            cap_t e;
            e = cap_q.pop_front();
            chk("cap_cycle", cyc - t0, e.cyc);
            chk("cap_row", int'(row_idx), e.row);
         end
      end
   end

   task automatic start_tile(input int cfg, input int n_rows, input int first_cap);
      @(posedge clk);
      #1;
      iv_from = 0; or_from = 0; inject_at = -1; bs_at = -1; rst_at = -1;
      suppress = 1'b0; inject_vr = 1'b0; RST = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      cfg_rows = 3'(cfg);
      start_req = 1'b1;
      t0 = cyc;
      shift_cyc = -1; done_cyc = -1; idle_cyc = -1; n_shift = 0; err_at_done = -1;
      ir1 = -1; err1 = -1; err6 = -1; err10 = -1; outs5 = -1; outs6 = -1;
      for (int k = 0; k < N; k++) ms_cyc[k] = -1;
      for (int i = 0; i < n_rows; i++) cap_q.push_back('{cyc: first_cap + 8 * i, row: i});
      @(negedge clk);
   endtask

   task automatic step();
      int rel;
      @(posedge clk);
      #1;
      rel = cyc - t0;
      start_req = (rel == bs_at);
      if (rel == bs_at) cfg_rows = 3'd4;
      in_valid  = (rel >= iv_from);
      out_ready = (rel >= or_from);
      inject_vr = (rel == inject_at);
      RST       = (rel == rst_at);
      @(negedge clk);
      if (mac_shift) begin
         n_shift++;
         if (shift_cyc < 0) shift_cyc = rel;
      end
      for (int k = 0; k < N; k++) if (mac_start[k] && ms_cyc[k] < 0) ms_cyc[k] = rel;
      if (done && done_cyc < 0) begin
         done_cyc = rel;
         err_at_done = int'(err);
      end
      if (!busy && idle_cyc < 0) idle_cyc = rel;
      if (rel == 1) begin ir1 = int'(in_ready); err1 = int'(err); end
      if (rel == 5) outs5 = int'(outs);
      if (rel == 6) begin outs6 = int'(outs); err6 = int'(err); end
      if (rel == 10) err10 = int'(err);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      RST = 1'b1; start_req = 1'b1; cfg_rows = 3'd1;
      in_valid = 1'b1; out_ready = 1'b1;
      iv_from = 0; or_from = 0; inject_at = -1; bs_at = -1; rst_at = -1;

      // Reset: all outputs low during and right after reset.
      repeat (3) begin
         @(negedge clk);
         chk("rst_outs", int'(outs), 0);
      end
      @(posedge clk);
      #1;
      RST = 1'b0; start_req = 1'b0;
      @(negedge clk);
      chk("post_rst_outs", int'(outs), 0);

      // Single row.
      start_tile(1, 1, 8);
      run(12);
      chk("t1_shift", shift_cyc, 1);
      for (int k = 0; k < N; k++) chk("t1_mac_start", ms_cyc[k], 2 + k);
      chk("t1_done", done_cyc, 9);
      chk("t1_idle", idle_cyc, 10);
      chk("t1_err", err_at_done, 0);
      chk("t1_nshift", n_shift, 1);
      chk("t1_sb_empty", cap_q.size(), 0);

      // Full tile via cfg_rows=0.
      start_tile(0, 4, 8);
      run(36);
      chk("t2_done", done_cyc, 33);
      chk("t2_nshift", n_shift, 4);
      chk("t2_idle", idle_cyc, 34);
      chk("t2_sb_empty", cap_q.size(), 0);

      // in_valid low for three LOAD cycles.
      start_tile(1, 1, 11);
      iv_from = 4;
      run(14);
      chk("t3_shift", shift_cyc, 4);
      chk("t3_done", done_cyc, 12);
      chk("t3_sb_empty", cap_q.size(), 0);

      // out_ready low during LOAD.
      start_tile(1, 1, 10);
      or_from = 3;
      run(13);
      chk("t4_in_ready", ir1, 0);
      chk("t4_shift", shift_cyc, 3);
      chk("t4_done", done_cyc, 11);
      chk("t4_sb_empty", cap_q.size(), 0);

      // Missing ready: sticky err held past done.
      start_tile(1, 1, 8);
      suppress = 1'b1;
      run(12);
      chk("t5_err_done", err_at_done, 1);
      chk("t5_err_idle", err10, 1);
      chk("t5_done", done_cyc, 9);
      chk("t5_sb_empty", cap_q.size(), 0);

      // Early ready at WAIT cycle 2; start clears previous err.
      start_tile(1, 1, 8);
      inject_at = 5;
      run(12);
      chk("t6_err_cleared", err1, 0);
      chk("t6_err_early", err6, 1);
      chk("t6_err_done", err_at_done, 1);
      chk("t6_done", done_cyc, 9);
      chk("t6_sb_empty", cap_q.size(), 0);

      // start_req while busy is ignored.
      start_tile(1, 1, 8);
      bs_at = 3;
      run(14);
      chk("t7_done", done_cyc, 9);
      chk("t7_nshift", n_shift, 1);
      chk("t7_idle", idle_cyc, 10);
      chk("t7_sb_empty", cap_q.size(), 0);

      // Oversized cfg_rows runs N rows.
      start_tile(7, 4, 8);
      run(36);
      chk("t8_done", done_cyc, 33);
      chk("t8_nshift", n_shift, 4);
      chk("t8_sb_empty", cap_q.size(), 0);

      // Reset at cycle 5 of a tile.
      start_tile(1, 0, 0);
      rst_at = 5;
      run(10);
      chk("t9_ms2", ms_cyc[2], 4);
      chk("t9_outs5", outs5, 0);
      chk("t9_outs6", outs6, 0);
      chk("t9_ms3", ms_cyc[3], -1);
      chk("t9_done", done_cyc, -1);
      chk("t9_sb_empty", cap_q.size(), 0);

      // Recovery after mid-tile reset.
      start_tile(1, 1, 8);
      run(12);
      chk("t10_shift", shift_cyc, 1);
      chk("t10_done", done_cyc, 9);
      chk("t10_err", err_at_done, 0);
      chk("t10_sb_empty", cap_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
